display_scanner: RTL and testbench
==================================

# display_scanner

Time-multiplexed driver for a four-digit seven-segment display. Holds a 16-bit value, scans one hex digit at a time, and presents that digit's nibble to the downstream hex-to-seven-segment decoder (4-bit `data` in, active-low segments out). It also drives the matching active-low digit enable. New values are accepted at any time but only take effect at a frame boundary, so a frame never shows digits from two different values.

## Interface
- `DIV`, default 50000: clock cycles per digit slot; legal range ≥ 1.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `load`  input  1  single-cycle strobe; capture `value` this cycle.
- `value`  input  16  value to display; nibble [15:12] is digit 3 (most significant), [3:0] is digit 0.
- `data`  output  4  nibble for the current digit; connects to the decoder `data` input.
- `an_n`  output  4  active-low digit enables; bit i selects digit i.
- `frame_start`  output  1  one-cycle pulse in the first cycle of each digit-0 slot.

## Operation
- State: prescaler `cnt` (0..DIV-1), digit index `dig` (0..3), displayed register `shown`[15:0], shadow register `shadow`[15:0], flag `pending`.
- Reset values: `cnt`=0, `dig`=0, `shown`=0, `shadow`=0, `pending`=0. Resulting outputs: `data`=4'h0, `an_n`=4'b1110, `frame_start`=0.
- Prescaler:
  - `cnt` increments each cycle.
  - When `cnt`=DIV-1, `cnt` returns to 0 and `dig` advances 0→1→2→3→0.
  - With DIV=1, `dig` advances every cycle.
- Frame boundary: the cycle with `cnt`=DIV-1 and `dig`=3.
- `load` not on a frame boundary: `shadow`←`value`, `pending`←1. A later `load` before the boundary overwrites `shadow`; last value wins.
- At a frame boundary with no `load`: if `pending`, then `shown`←`shadow` and `pending`←0.
- At a frame boundary with `load` in the same cycle: `shown`←`value` directly, `shadow`←`value`, `pending`←0.
- Outputs are a combinational decode of the registered `dig` and `shown`:
  - `data`=`shown`[4·dig+3 : 4·dig].
  - `an_n`=~(1<<dig), so exactly one bit is low unless the digit is blanked (see Configuration).
- `frame_start`=1 when `dig`=0 and `cnt`=0, except in the first cycle after reset release. The first post-reset pulse therefore comes at the start of the second frame.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous), including discarding a pending value.

## Timing
- `data` and `an_n` change on the same clock edge that updates `dig`. There is no added pipeline stage.
- Each digit is active for exactly DIV cycles. One full frame is 4·DIV cycles.
- Load-to-display latency, measured from the `load` cycle to the first cycle of `dig`=0 showing the new value:
  - worst case 4·DIV cycles (load in the first cycle of a frame);
  - best case 1 cycle (load on the boundary).
- `load` is never back-pressured; there is no ready signal.

## Configuration
- `LEADING_ZERO_BLANK_EN` defined:
  - During the slot of digit i (i ≥ 1), `an_n`=4'b1111 if `shown`[15:4·i] is all zero.
  - Digit 0 is never blanked, so a value of 0 shows a single "0".
  - `data` still carries the nibble.
- `LEADING_ZERO_BLANK_EN` undefined: all four digits are always enabled in turn; leading zeros are displayed.

## Test plan
- Reset, DIV=4, no load:
  - `an_n` sequence 1110,1101,1011,0111, each held 4 cycles, repeating;
  - `data`=0 throughout;
  - `frame_start` pulses every 16 cycles.
- `load` with `value`=16'hA3F1 mid-frame (dig=1) → no output change until the boundary. Next frame `data` sequence is 1,F,3,A in slots 0..3.
- Two loads in one frame (16'h1234, then 16'h5678) → only 5,6,7,8 ever shown (as 8,7,6,5 by digit index); 1234 never appears.
- `load` 16'hBEEF exactly on a boundary cycle → the very next cycle shows `dig`=0 with `data`=F.
- `resetn` pulsed low during dig=2 with `pending`=1 → outputs return to `data`=0, `an_n`=1110 without waiting for a clock edge; the pending value is never displayed.
- With `LEADING_ZERO_BLANK_EN`, `value`=16'h0050:
  - digit slots 3 and 2: `an_n`=1111;
  - slot 1: `an_n`=1101, `data`=5;
  - slot 0: `an_n`=1110, `data`=0.
  - Without the macro: all four digits enabled, showing 0,0,5,0.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: four-digit seven-segment scan driver with frame-aligned value update.
// Ports: clock, resetn, load, value[15:0] -> data[3:0], an_n[3:0], frame_start; macro LEADING_ZERO_BLANK_EN.
module display_scanner #(
  parameter int unsigned DIV = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        load,
  input  logic [15:0] value,
  output logic [3:0]  data,
  output logic [3:0]  an_n,
  output logic        frame_start
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   shown_q, shown_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic          first_q;

  logic slot_end;
  logic boundary;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      dig_q    <= 2'd0;
      shown_q  <= 16'h0000;
      shadow_q <= 16'h0000;
      pend_q   <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      shown_q  <= shown_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      first_q  <= 1'b0;
    end
  end

  always_comb begin
    slot_end = (cnt_q == CNT_MAX);
    boundary = slot_end && (dig_q == 2'd3);
    cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
    dig_d    = slot_end ? dig_q + 2'd1 : dig_q;
    shown_d  = shown_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    unique case (1'b1)
      boundary && load: begin
        shown_d  = value;
        shadow_d = value;
        pend_d   = 1'b0;
      end
      boundary && !load && pend_q: begin
        shown_d = shadow_q;
        pend_d  = 1'b0;
      end
      !boundary && load: begin
        shadow_d = value;
        pend_d   = 1'b1;
      end
      default: ;
    endcase
  end

  logic [15:0] hi_mask;
  logic        blank;
  logic [3:0]  one_hot;

  always_comb begin
    data    = shown_q[{dig_q, 2'b00} +: 4];
    one_hot = 4'b0001 << dig_q;
    hi_mask = 16'hFFFF << {dig_q, 2'b00};
`ifdef LEADING_ZERO_BLANK_EN
    // digit 0 always shows, so a zero value still displays "0"
    blank = (dig_q != 2'd0) && ((shown_q & hi_mask) == 16'h0000);
`else
    blank = 1'b0;
`endif
    an_n = blank ? 4'b1111 : ~one_hot;
    // suppressed in the very first cycle after reset release
    frame_start = (dig_q == 2'd0) && (cnt_q == '0) && !first_q;
  end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner: scoreboard bench for display_scanner with DIV=4.
// Per-cycle expectations come from a frame-position model.
module tb_display_scanner;

  localparam int DIV = 4;
  localparam int FR  = 4 * DIV;

  typedef struct packed {
    logic [3:0] data;
    logic [3:0] an;
    logic       fs;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic [3:0]  data;
  logic [3:0]  an_n;
  logic        frame_start;

  int n_cmp = 0;
  int n_err = 0;

  int          m_t;
  logic [15:0] m_shown;
  logic [15:0] m_shadow;
  logic        m_pend;

  exp_t sb[$];

  display_scanner #(.DIV(DIV)) dut (
    .clock(clock),
    .resetn(resetn),
    .load(load),
    .value(value),
    .data(data),
    .an_n(an_n),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  function automatic exp_t predict();
    exp_t        e;
    int          d;
    logic [15:0] s;
    logic [3:0]  one;
    d      = (m_t / DIV) % 4;
    s      = m_shown >> (4 * d);
    one    = 4'b0001;
    e.data = s[3:0];
    e.an   = ~(one << d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0 && s == 16'h0000) e.an = 4'hF;
`endif
    e.fs = (m_t % FR == 0) && (m_t != 0);
    return e;
  endfunction

  task automatic model_reset();
    m_t      = 0;
    m_shown  = 16'h0000;
    m_shadow = 16'h0000;
    m_pend   = 1'b0;
    sb.delete();
  endtask

  task automatic check_now(input string tag);
    exp_t e;
    e = predict();
    check({tag, "_data"}, {12'h0, data}, {12'h0, e.data});
    check({tag, "_an"}, {12'h0, an_n}, {12'h0, e.an});
    check({tag, "_fs"}, {15'h0, frame_start}, {15'h0, e.fs});
  endtask

  task automatic cyc(input logic ld, input logic [15:0] v);
    exp_t e;
    load  = ld;
    value = v;
    if (m_t % FR == FR - 1) begin
      if (ld) begin
        m_shown  = v;
        m_shadow = v;
        m_pend   = 1'b0;
      end else if (m_pend) begin
        m_shown = m_shadow;
        m_pend  = 1'b0;
      end
    end else if (ld) begin
      m_shadow = v;
      m_pend   = 1'b1;
    end
    m_t++;
    sb.push_back(predict());
    @(posedge clock);
    #1;
    load = 1'b0;
    e = sb.pop_front();
    check($sformatf("data@%0d", m_t), {12'h0, data}, {12'h0, e.data});
    check($sformatf("an@%0d", m_t), {12'h0, an_n}, {12'h0, e.an});
    check($sformatf("fs@%0d", m_t), {15'h0, frame_start}, {15'h0, e.fs});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000);
  endtask

  task automatic wait_pos(input int p);
    while (m_t % FR != p) cyc(1'b0, 16'h0000);
  endtask

  task automatic release_reset(input string tag);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    model_reset();
    check({tag, "_data0"}, {12'h0, data}, 16'h0000);
    check({tag, "_an0"}, {12'h0, an_n}, 16'h000E);
    check({tag, "_fs0"}, {15'h0, frame_start}, 16'h0000);
    check_now(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_async_data", {12'h0, data}, 16'h0000);
    check("rst_async_an", {12'h0, an_n}, 16'h000E);
    check("rst_async_fs", {15'h0, frame_start}, 16'h0000);
    release_reset("rst");

    run(3 * FR);

    wait_pos(DIV + 1);
    cyc(1'b1, 16'hA3F1);
    run(2 * FR);

    wait_pos(1);
    cyc(1'b1, 16'h1234);
    run(3);
    cyc(1'b1, 16'h5678);
    run(2 * FR + 3);

    wait_pos(FR - 1);
    cyc(1'b1, 16'hBEEF);
    check("beef_data", {12'h0, data}, 16'h000F);
    check("beef_an", {12'h0, an_n}, 16'h000E);
    run(FR + 4);

    wait_pos(2);
    cyc(1'b1, 16'h0050);
    run(2 * FR);

    wait_pos(3);
    cyc(1'b1, 16'hC9D2);
    run(FR);
    wait_pos(2 * DIV + 1);
    cyc(1'b1, 16'h7777);
    cyc(1'b0, 16'h0000);
    #2;
    resetn = 1'b0;
    #1;
    check("mid_rst_data", {12'h0, data}, 16'h0000);
    check("mid_rst_an", {12'h0, an_n}, 16'h000E);
    check("mid_rst_fs", {15'h0, frame_start}, 16'h0000);
    release_reset("rst2");
    run(3 * FR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
